// File: rtl/serial_add_32_if.sv
// Handshake and operand/result bundle for the digit-serial adder.
// Master side requests additions; slave side reports busy/done and the registered result.
interface serial_add_32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;

    modport master (
        output start, x, y, cin,
        input  busy, done, s, cout
    );

    modport slave (
        input  start, x, y, cin,
        output busy, done, s, cout
    );
endinterface

// File: rtl/serial_add_32.sv
// Digit-serial adder: s = x + y + cin, DIGIT bits per clock, LSB first, one shared adder slice.
// Latency WIDTH/DIGIT cycles from accept to done; start is ignored while busy, accepted in IDLE or DONE.
module serial_add_32 #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_add_32_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = DIGIT + 1;

    generate
        if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_bad_digit
            $error("serial_add_32: DIGIT must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  xw_q, yw_q, sw_q, s_q;
    logic              c_q, cout_q;
    logic [CW-1:0]     cnt_q;

    logic [SW-1:0]     slice_d;
    logic [WIDTH-1:0]  sw_d;

    // New sum digits enter at the top so that after N shifts the LSB digit sits at bit 0.
    always_comb begin
        slice_d = SW'(xw_q[DIGIT-1:0]) + SW'(yw_q[DIGIT-1:0]) + SW'(c_q);
        sw_d    = (sw_q >> DIGIT) | (WIDTH'(slice_d[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            xw_q    <= '0;
            yw_q    <= '0;
            sw_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        xw_q    <= bus.x;
                        yw_q    <= bus.y;
                        c_q     <= bus.cin;
                        sw_q    <= '0;
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    xw_q  <= xw_q >> DIGIT;
                    yw_q  <= yw_q >> DIGIT;
                    c_q   <= slice_d[DIGIT];
                    sw_q  <= sw_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        s_q     <= sw_d;
                        cout_q  <= slice_d[DIGIT];
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_32.sv
// Directed and subtractor-cross-check bench for serial_add_32 (DIGIT=1 and DIGIT=4 instances).
module tb_serial_add_32;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_add_32_if #(.WIDTH(32)) bus ();
    serial_add_32_if #(.WIDTH(32)) bus4 ();

    serial_add_32 #(.WIDTH(32), .DIGIT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    serial_add_32 #(.WIDTH(32), .DIGIT(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] prev_s;
    logic        prev_c;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic ci);
        bus.start = 1'b1;
        bus.x     = a;
        bus.y     = b;
        bus.cin   = ci;
        @(negedge clk);
        bus.start = 1'b0;
        bus.x     = $urandom;
        bus.y     = $urandom;
        bus.cin   = 1'($urandom);
    endtask

    // Counts busy cycles, then checks the done cycle; returns at the done negedge.
    task automatic wait_done(input string tag, input logic [31:0] es, input logic ec,
                             input bit hold, input bit inj);
        int n = 0;
        while (bus.busy && n < 200) begin
            if (hold && n == 5) begin
                chk({tag, "_hold_s"}, 64'(bus.s), 64'(prev_s));
                chk({tag, "_hold_c"}, 64'(bus.cout), 64'(prev_c));
            end
            if (inj) begin
                bus.start = (n == 10);
                bus.x     = 32'hFFFF_0000;
                bus.y     = 32'h0000_1234;
            end
            n++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({tag, "_busy_cycles"}, 64'(n), 64'd32);
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({tag, "_s"}, 64'(bus.s), 64'(es));
        chk({tag, "_cout"}, 64'(bus.cout), 64'(ec));
        prev_s = es;
        prev_c = ec;
    endtask

    initial begin
        logic [31:0] a, b;
        int          n, dcount;

        rst_n      = 1'b0;
        bus.start  = 1'b0; bus.x  = '0; bus.y  = '0; bus.cin  = 1'b0;
        bus4.start = 1'b0; bus4.x = '0; bus4.y = '0; bus4.cin = 1'b0;
        prev_s = '0;
        prev_c = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_s", 64'(bus.s), 64'd0);
        chk("rst_cout", 64'(bus.cout), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        start_op(32'h5, 32'h3, 1'b0);
        wait_done("basic", 32'h8, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("basic_done_once", 64'(bus.done), 64'd0);
        chk("basic_s_kept", 64'(bus.s), 64'h8);

        start_op(32'hFFFF_FFFF, 32'h0, 1'b1);
        wait_done("ripple", 32'h0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);

        start_op(32'h7FFF_FFFF, 32'h1, 1'b1);
        wait_done("mixed", 32'h8000_0001, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        start_op(32'h10, ~32'h20, 1'b1);
        wait_done("sub_ex", 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        start_op(32'd100, 32'd23, 1'b0);
        wait_done("ignore", 32'd123, 1'b0, 1'b1, 1'b1);
        @(negedge clk);

        // Second request issued in the DONE cycle itself.
        start_op(32'h1111, 32'h2222, 1'b0);
        wait_done("b2b_a", 32'h3333, 1'b0, 1'b1, 1'b0);
        start_op(32'hF000_0000, 32'h1000_0000, 1'b0);
        wait_done("b2b_b", 32'h0, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            start_op(a, ~b, 1'b1);
            wait_done("sub_rand", a - b, (a >= b), 1'b0, 1'b0);
        end
        @(negedge clk);

        start_op(32'h55, 32'h66, 1'b0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_s", 64'(bus.s), 64'd0);
        chk("midrst_cout", 64'(bus.cout), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        chk("midrst_no_done", 64'(dcount), 64'd0);
        chk("midrst_s_after", 64'(bus.s), 64'd0);

        bus4.start = 1'b1;
        bus4.x     = 32'hDEAD_BEEF;
        bus4.y     = 32'h2152_4111;
        bus4.cin   = 1'b0;
        @(negedge clk);
        bus4.start = 1'b0;
        bus4.x     = '0;
        bus4.y     = '0;
        n = 0;
        while (bus4.busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("d4_busy_cycles", 64'(n), 64'd8);
        chk("d4_done", 64'(bus4.done), 64'd1);
        chk("d4_s", 64'(bus4.s), 64'h0);
        chk("d4_cout", 64'(bus4.cout), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
